// File: rtl/waveform_loop_fifo_if.sv
// rtl/waveform_loop_fifo_if.sv - stream handshake bundle for the waveform loop buffer
interface waveform_loop_fifo_if #(
    parameter int DATA_W = 256
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/waveform_loop_fifo.sv
// rtl/waveform_loop_fifo.sv - FWFT waveform buffer feeding the DAC stage, with load/loop/flush modes
module waveform_loop_fifo #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    waveform_loop_fifo_if.slave  s_axis,
    input  logic [DATA_W-1:0]   loop_tdata,
    input  logic                loop_valid,
    input  logic                mux_sel,
    input  logic                flush,
    waveform_loop_fifo_if.master m_axis,
    output logic [ADDR_W:0]     count,
    output logic                overflow
);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_LOAD, ST_LOOP, ST_FLUSH} mode_t;

    mode_t             state;
    mode_t             state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push_req;
    logic              do_write;
    logic              clear;
    logic              load_ready;
    logic [DATA_W-1:0] wr_data;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    assign m_axis.tvalid = !empty;
    assign m_axis.tdata  = empty ? '0 : mem[rd_ptr];
    assign pop           = m_axis.tvalid & m_axis.tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // A flush pulse clears at the edge that enters FLUSH, so the FLUSH cycle itself already reads empty.
    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        push_req   = 1'b0;
        clear      = 1'b0;
        wr_data    = s_axis.tdata;
        case (state)
            ST_LOAD: begin
                load_ready = !rst & !flush & (!full | pop);
                push_req   = s_axis.tvalid & load_ready;
                clear      = flush;
                if (flush) begin
                    state_nxt = ST_FLUSH;
                end else if (mux_sel) begin
                    state_nxt = ST_LOOP;
                end
            end
            ST_LOOP: begin
                push_req = loop_valid;
                wr_data  = loop_tdata;
                clear    = flush;
                if (flush) begin
                    state_nxt = ST_FLUSH;
                end else if (!mux_sel) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                clear     = 1'b1;
                state_nxt = mux_sel ? ST_LOOP : ST_LOAD;
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    assign s_axis.tready = load_ready;
    assign do_write      = push_req & (!full | pop) & !clear;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Only loop mode can reach here while full; load mode is held off by tready.
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
            case ({do_write, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_waveform_loop_fifo.sv
// tb/tb_waveform_loop_fifo.sv - scoreboard bench for waveform_loop_fifo
module tb_waveform_loop_fifo;
    localparam int DW    = 256;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] loop_tdata;
    logic          loop_valid;
    logic          mux_sel;
    logic          flush;
    logic [6:0]    count;
    logic          overflow;

    waveform_loop_fifo_if #(.DATA_W(DW)) s_axis_if ();
    waveform_loop_fifo_if #(.DATA_W(DW)) m_axis_if ();

    waveform_loop_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axis     (s_axis_if),
        .loop_tdata (loop_tdata),
        .loop_valid (loop_valid),
        .mux_sel    (mux_sel),
        .flush      (flush),
        .m_axis     (m_axis_if),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q [$];
    int            m_mode;
    logic          m_ovf;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_mode = 0;
        m_ovf  = 1'b0;
    endtask

    // One clock: check combinational outputs against the model, advance the model, check registered state.
    task automatic tick(output logic popped, output logic [DW-1:0] pword);
        logic exp_valid, full, pop, exp_ready, push_req, clr;
        logic [DW-1:0] wdata;
        #1;
        exp_valid = (exp_q.size() != 0);
        check_eq("m_tvalid", DW'(m_axis_if.tvalid), DW'(exp_valid));
        if (exp_valid) check_eq("m_tdata", m_axis_if.tdata, exp_q[0]);
        else           check_eq("m_tdata_empty", m_axis_if.tdata, '0);
        full      = (exp_q.size() == DEPTH);
        pop       = exp_valid & m_axis_if.tready;
        exp_ready = (m_mode == 0) & !flush & (!full | pop);
        check_eq("s_tready", DW'(s_axis_if.tready), DW'(exp_ready));
        push_req = (m_mode == 0) ? (s_axis_if.tvalid & exp_ready) :
                   (m_mode == 1) ? loop_valid : 1'b0;
        wdata    = (m_mode == 1) ? loop_tdata : s_axis_if.tdata;
        clr      = (m_mode == 2) | flush;
        popped   = pop;
        pword    = pop ? m_axis_if.tdata : '0;
        @(posedge clk);
        if (clr) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push_req) begin
                if (!full || pop) exp_q.push_back(wdata);
                else              m_ovf = 1'b1;
            end
        end
        if (m_mode == 2)  m_mode = mux_sel ? 1 : 0;
        else if (flush)   m_mode = 2;
        else              m_mode = mux_sel ? 1 : 0;
        #1;
        check_eq("count", DW'(count), DW'(exp_q.size()));
        check_eq("overflow", DW'(overflow), DW'(m_ovf));
    endtask

    task automatic step();
        logic p;
        logic [DW-1:0] w;
        tick(p, w);
    endtask

    task automatic load_word(input logic [DW-1:0] d);
        s_axis_if.tvalid = 1'b1;
        s_axis_if.tdata  = d;
        step();
        s_axis_if.tvalid = 1'b0;
    endtask

    initial begin
        logic          p, v1, v2;
        logic [DW-1:0] w, d1, d2;
        int            pops;

        rst = 1'b1;
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tdata  = '0;
        m_axis_if.tready = 1'b0;
        loop_tdata = '0;
        loop_valid = 1'b0;
        mux_sel    = 1'b0;
        flush      = 1'b0;
        model_reset();
        #3;
        check_eq("rst_count", DW'(count), '0);
        check_eq("rst_overflow", DW'(overflow), '0);
        check_eq("rst_s_tready", DW'(s_axis_if.tready), '0);
        check_eq("rst_m_tvalid", DW'(m_axis_if.tvalid), '0);
        check_eq("rst_m_tdata", m_axis_if.tdata, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load 1..8 with no reads
        for (int i = 1; i <= 8; i++) load_word(DW'(i));
        step();
        check_eq("load8_count", DW'(count), DW'(8));
        check_eq("load8_head", m_axis_if.tdata, DW'(1));
        check_eq("load8_tvalid", DW'(m_axis_if.tvalid), DW'(1));

        // Fill to DEPTH, then push and pop together at full
        for (int i = 9; i <= DEPTH; i++) load_word(DW'(i));
        s_axis_if.tvalid = 1'b1;
        s_axis_if.tdata  = DW'(32'hAA);
        #1;
        check_eq("full_tready", DW'(s_axis_if.tready), '0);
        step();
        m_axis_if.tready = 1'b1;
        s_axis_if.tdata  = DW'(32'hBB);
        step();
        m_axis_if.tready = 1'b0;
        s_axis_if.tvalid = 1'b0;
        check_eq("full_pushpop_count", DW'(count), DW'(DEPTH));
        check_eq("full_pushpop_head", m_axis_if.tdata, DW'(2));

        // Loop mode overflow while full, then flush
        mux_sel = 1'b1;
        step();
        loop_valid = 1'b1;
        loop_tdata = DW'(32'hCC);
        step();
        loop_valid = 1'b0;
        check_eq("ovf_set", DW'(overflow), DW'(1));
        check_eq("ovf_count", DW'(count), DW'(DEPTH));
        flush   = 1'b1;
        mux_sel = 1'b0;
        step();
        flush = 1'b0;
        check_eq("flush_count", DW'(count), '0);
        check_eq("flush_overflow", DW'(overflow), '0);
        step();

        // Loop replay: 4 words, fed back 2 cycles after each pop, 3 passes
        for (int i = 1; i <= 4; i++) load_word(DW'(i));
        mux_sel = 1'b1;
        step();
        v1 = 1'b0; v2 = 1'b0; d1 = '0; d2 = '0; pops = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            m_axis_if.tready = (pops < 12);
            loop_valid = v2;
            loop_tdata = d2;
            tick(p, w);
            if (p) begin
                check_eq("loop_seq", w, DW'((pops % 4) + 1));
                pops++;
            end
            v2 = v1; d2 = d1;
            v1 = p;  d1 = w;
        end
        m_axis_if.tready = 1'b0;
        loop_valid = 1'b0;
        check_eq("loop_pops", DW'(pops), DW'(12));
        check_eq("loop_count", DW'(count), DW'(4));

        // Empty buffer: push and read enable together
        flush   = 1'b1;
        mux_sel = 1'b0;
        step();
        flush = 1'b0;
        step();
        s_axis_if.tvalid = 1'b1;
        s_axis_if.tdata  = DW'(32'h55);
        m_axis_if.tready = 1'b1;
        #1;
        check_eq("empty_pp_tvalid", DW'(m_axis_if.tvalid), '0);
        step();
        s_axis_if.tvalid = 1'b0;
        m_axis_if.tready = 1'b0;
        check_eq("empty_pp_count", DW'(count), DW'(1));
        check_eq("empty_pp_data", m_axis_if.tdata, DW'(32'h55));
        m_axis_if.tready = 1'b1;
        step();
        m_axis_if.tready = 1'b0;

        // Reset in the middle of a load
        for (int i = 0; i < 5; i++) load_word(DW'(32'h10 + i));
        check_eq("pre_rst_count", DW'(count), DW'(5));
        s_axis_if.tvalid = 1'b1;
        s_axis_if.tdata  = DW'(32'h99);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_count", DW'(count), '0);
        check_eq("mid_rst_m_tvalid", DW'(m_axis_if.tvalid), '0);
        check_eq("mid_rst_m_tdata", m_axis_if.tdata, '0);
        check_eq("mid_rst_s_tready", DW'(s_axis_if.tready), '0);
        check_eq("mid_rst_overflow", DW'(overflow), '0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_axis_if.tvalid = 1'b0;
        for (int i = 0; i < 3; i++) load_word(DW'(32'h20 + i));
        check_eq("post_rst_count", DW'(count), DW'(3));
        check_eq("post_rst_head", m_axis_if.tdata, DW'(32'h20));
        m_axis_if.tready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        m_axis_if.tready = 1'b0;
        check_eq("drain_count", DW'(count), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
